// File: rtl/combi_sweep_if.sv
// combi_sweep_if: control, golden-mask and result bundle between test control and the sweep sequencer
interface combi_sweep_if #(parameter int N_IN = 4);
  logic              start;
  logic              abort;
  logic [2**N_IN-1:0] expect_mask;
  logic              y_in;
  logic [N_IN-1:0]   vec_out;
  logic              busy;
  logic              done;
  logic              pass;
  logic [N_IN:0]     err_count;
  logic [N_IN-1:0]   first_fail_vec;
  logic              first_fail_valid;
  modport master (
    output start, abort, expect_mask, y_in,
    input  vec_out, busy, done, pass, err_count, first_fail_vec, first_fail_valid
  );
  modport slave (
    input  start, abort, expect_mask, y_in,
    output vec_out, busy, done, pass, err_count, first_fail_vec, first_fail_valid
  );
endinterface

// File: rtl/combi_sweep_ctrl.sv
// combi_sweep_ctrl: sweeps every input vector of a combinational block and scores y against a golden mask
module combi_sweep_ctrl #(
  parameter int N_IN          = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input logic          clk,
  input logic          rst,
  combi_sweep_if.slave bus
);
  localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
  state_t             state, state_nx;
  logic [2**N_IN-1:0] mask;
  logic [N_IN-1:0]    vec;
  logic [SW-1:0]      settle_cnt;
  logic [N_IN:0]      err_count;
  logic [N_IN-1:0]    ff_vec;
  logic               ff_valid;
  logic               pass;
  logic               running, settle_end, last_vec, mismatch;
  assign running    = state == SETTLE || state == SAMPLE;
  assign settle_end = settle_cnt == SW'(SETTLE_CYCLES - 1);
  assign last_vec   = &vec;
  assign mismatch   = bus.y_in != mask[vec];
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = bus.start ? SETTLE : IDLE;
      SETTLE:  state_nx = bus.abort ? IDLE : settle_end ? SAMPLE : SETTLE;
      SAMPLE:  state_nx = bus.abort ? IDLE : last_vec ? DONE : SETTLE;
      default: state_nx = IDLE;
    endcase
  end
  // vec wraps to 0 after the last sample, so vec_out is already 0 once the sweep ends
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mask       <= '0;
      vec        <= '0;
      settle_cnt <= '0;
      err_count  <= '0;
      ff_vec     <= '0;
      ff_valid   <= 1'b0;
      pass       <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.start) begin
        mask       <= bus.expect_mask;
        vec        <= '0;
        settle_cnt <= '0;
        err_count  <= '0;
        ff_vec     <= '0;
        ff_valid   <= 1'b0;
        pass       <= 1'b0;
      end else if (running && bus.abort) begin
        vec        <= '0;
        settle_cnt <= '0;
        pass       <= 1'b0;
      end else if (state == SETTLE) begin
        settle_cnt <= settle_cnt + SW'(1);
      end else if (state == SAMPLE) begin
        vec        <= vec + N_IN'(1);
        settle_cnt <= '0;
        if (mismatch) begin
          err_count <= err_count + (N_IN+1)'(1);
          if (!ff_valid) begin
            ff_vec   <= vec;
            ff_valid <= 1'b1;
          end
        end
      end else if (state == DONE) begin
        pass <= err_count == '0;
      end
    end
  end
  assign bus.vec_out          = vec;
  assign bus.busy             = running;
  assign bus.done             = state == DONE;
  assign bus.pass             = pass;
  assign bus.err_count        = err_count;
  assign bus.first_fail_vec   = ff_vec;
  assign bus.first_fail_valid = ff_valid;
endmodule

// File: tb/tb_combi_sweep_ctrl.sv
// tb_combi_sweep_ctrl: scoreboard bench; expected sweep results queued at start, checked on done
module tb_combi_sweep_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stuck = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  typedef struct {
    string      name;
    int         done_at;
    logic [4:0] err;
    logic [3:0] ff_vec;
    logic       ff_valid;
    logic       pass;
  } exp_t;
  exp_t sb[$];
  exp_t pe;
  bit   pend = 1'b0;
  combi_sweep_if #(.N_IN(4)) bus();
  combi_sweep_ctrl #(.N_IN(4), .SETTLE_CYCLES(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic fn(input logic [3:0] v);
    return !((v[3] & v[2]) & ((v[2] & v[1]) | (v[1] | v[0])));
  endfunction
  assign bus.y_in = stuck ? 1'b1 : fn(bus.vec_out);
  function automatic exp_t predict(input string name, input logic [15:0] m, input logic st, input int at);
    exp_t e;
    e.name = name; e.done_at = at; e.err = '0; e.ff_vec = '0; e.ff_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      logic y;
      y = st ? 1'b1 : fn(4'(k));
      if (y != m[k]) begin
        e.err++;
        if (!e.ff_valid) begin e.ff_vec = 4'(k); e.ff_valid = 1'b1; end
      end
    end
    e.pass = e.err == 0;
    return e;
  endfunction
  // consumer side of the scoreboard: every done pulse must match the oldest queued sweep
  always @(posedge clk) begin
    #1;
    if (pend) begin
      pend = 1'b0;
      checks++;
      if (bus.pass !== pe.pass || bus.err_count !== pe.err) begin
        failures++;
        $display("FAIL %s_after_done pass=%0b err=%0d expected pass=%0b err=%0d", pe.name, bus.pass, bus.err_count, pe.pass, pe.err);
      end
    end
    if (!rst && bus.done) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done at cycle %0d expected no done", cyc);
      end else begin
        pe = sb.pop_front();
        pend = 1'b1;
        if (cyc !== pe.done_at || bus.busy !== 1'b0 || bus.err_count !== pe.err ||
            bus.first_fail_vec !== pe.ff_vec || bus.first_fail_valid !== pe.ff_valid) begin
          failures++;
          $display("FAIL %s_done cyc=%0d busy=%0b err=%0d ffv=%h ffval=%0b expected cyc=%0d busy=0 err=%0d ffv=%h ffval=%0b",
                   pe.name, cyc, bus.busy, bus.err_count, bus.first_fail_vec, bus.first_fail_valid,
                   pe.done_at, pe.err, pe.ff_vec, pe.ff_valid);
        end
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic start_sweep(input string name, input logic [15:0] m, input logic st, input bit push);
    bus.expect_mask = m;
    stuck = st;
    bus.start = 1'b1;
    if (push) sb.push_back(predict(name, m, st, cyc + 49));
    step();
    bus.start = 1'b0;
  endtask
  task automatic wait_idle(input string name);
    int n = 0;
    while ((sb.size() != 0 || pend) && n < 200) begin step(); n++; end
    if (n >= 200) begin
      checks++; failures++;
      $display("FAIL %s_timeout pending=%0d expected 0", name, sb.size());
      sb.delete();
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++;
    if ({bus.vec_out, bus.busy, bus.done, bus.pass, bus.err_count, bus.first_fail_vec, bus.first_fail_valid} !== '0) begin
      failures++;
      $display("FAIL reset_outputs vec=%h busy=%0b done=%0b pass=%0b err=%0d expected all 0", bus.vec_out, bus.busy, bus.done, bus.pass, bus.err_count);
    end
    rst = 1'b0;
    step();
  endtask
  task automatic test_function();
    start_sweep("t1_model", 16'h1FFF, 1'b0, 1'b1);
    wait_idle("t1_model");
    start_sweep("t2_stuck1", 16'h1FFF, 1'b1, 1'b1);
    wait_idle("t2_stuck1");
    start_sweep("t3_mask0", 16'h0000, 1'b0, 1'b1);
    wait_idle("t3_mask0");
  endtask
  task automatic test_trace();
    start_sweep("t4_trace", 16'h1FFF, 1'b0, 1'b1);
    for (int c = 1; c <= 49; c++) begin
      if (c <= 48) begin
        checks++;
        if (bus.vec_out !== 4'((c - 1) / 3) || bus.busy !== 1'b1) begin
          failures++;
          $display("FAIL t4_trace cycle %0d vec=%h busy=%0b expected vec=%h busy=1", c, bus.vec_out, bus.busy, 4'((c - 1) / 3));
        end
      end
      bus.start = (c == 10 || c == 49);
      if (c == 10) bus.expect_mask = 16'h0000;
      step();
    end
    bus.start = 1'b0;
    wait_idle("t4_trace");
  endtask
  task automatic test_abort();
    start_sweep("t5_abort", 16'h0000, 1'b0, 1'b0);
    for (int c = 1; c < 20; c++) step();
    bus.abort = 1'b1;
    bus.start = 1'b1;
    step();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.vec_out !== 4'h0 || bus.pass !== 1'b0 || bus.err_count !== 5'd6 ||
        bus.first_fail_valid !== 1'b1 || bus.first_fail_vec !== 4'h0) begin
      failures++;
      $display("FAIL t5_after_abort busy=%0b vec=%h pass=%0b err=%0d ffval=%0b expected busy=0 vec=0 pass=0 err=6 ffval=1",
               bus.busy, bus.vec_out, bus.pass, bus.err_count, bus.first_fail_valid);
    end
    for (int c = 0; c < 60; c++) step();
    checks++;
    if (bus.busy !== 1'b0 || bus.err_count !== 5'd6) begin
      failures++;
      $display("FAIL t5_hold busy=%0b err=%0d expected busy=0 err=6", bus.busy, bus.err_count);
    end
    start_sweep("t5_restart", 16'h1FFF, 1'b0, 1'b1);
    wait_idle("t5_restart");
  endtask
  task automatic test_rst_mid();
    start_sweep("t6_pre", 16'h0000, 1'b0, 1'b0);
    for (int c = 1; c < 30; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({bus.vec_out, bus.busy, bus.done, bus.pass, bus.err_count, bus.first_fail_vec, bus.first_fail_valid} !== '0) begin
      failures++;
      $display("FAIL t6_rst_outputs vec=%h busy=%0b err=%0d ffval=%0b expected all 0", bus.vec_out, bus.busy, bus.err_count, bus.first_fail_valid);
    end
    for (int c = 31; c < 35; c++) step();
    start_sweep("t6_after_rst", 16'h1FFF, 1'b0, 1'b1);
    wait_idle("t6_after_rst");
  endtask
  task automatic test_back_to_back();
    start_sweep("b2b_first", 16'h1FFF, 1'b1, 1'b1);
    wait_idle("b2b_first");
    start_sweep("b2b_second", 16'h1FFF, 1'b0, 1'b1);
    wait_idle("b2b_second");
  endtask
  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.expect_mask = '0;
    test_reset();
    test_function();
    test_trace();
    test_abort();
    test_rst_mid();
    test_back_to_back();
    step(); step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
